mem_bus_responder: RTL
======================

MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

Interface
REQ-001 SHALL have parameter RAM_ADDR_WID, default 17, giving the byte-RAM index width (128 KiB).
REQ-002 SHALL have parameter TX_DEPTH, default 8, giving the TX FIFO depth in bytes (power of two).
REQ-003 SHALL have parameter RX_DEPTH, default 4, giving the RX FIFO depth in bytes (power of two).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port rdy  input  1  bus-side enable; when low, the bus side holds.
REQ-007 SHALL have port call_addr  input  32  byte address from the initiator.
REQ-008 SHALL have port is_write  input  1  1 means write this cycle, 0 means read.
REQ-009 SHALL have port write_data  input  8  write byte.
REQ-010 SHALL have port ret_data  output  8  read byte, registered.
REQ-011 SHALL have port io_buffer_full  output  1  TX FIFO near-full backpressure.
REQ-012 SHALL have port uart_tx_valid, uart_tx_data  output  1/8  TX byte offer.
REQ-013 SHALL have port uart_tx_ready  input  1  TX byte accepted.
REQ-014 SHALL have port uart_rx_valid, uart_rx_data  input  1/8  RX byte push.
REQ-015 SHALL have port sim_halt  output  1  one-cycle program-end pulse.
REQ-016 SHALL have port tx_overflow  output  1  sticky flag for a dropped TX byte.

Function
REQ-017 SHALL decode addresses as IO when call_addr[17:16]==2'b11, and as RAM otherwise, using index call_addr[RAM_ADDR_WID-1:0].
REQ-018 SHALL, on each clock with rdy=1 and is_write=0, load ret_data with the addressed byte, giving one-cycle read latency for every read (RAM and IO).
REQ-019 SHALL, on each clock with rdy=1 and is_write=1, write write_data to RAM or perform the IO write, and leave ret_data unchanged.
REQ-020 SHALL, when rdy=0, perform no write, no FIFO push, and no FIFO pop from the bus, and SHALL hold ret_data.
REQ-021 SHALL, on an IO write to 0x30000, push the byte into the TX FIFO; if the FIFO is full, SHALL drop the byte and set tx_overflow.
REQ-022 SHALL, on an IO write to 0x30004, pulse sim_halt for exactly one cycle; the data is ignored.
REQ-023 SHALL, on an IO read of 0x30000, return the RX FIFO head and pop it; if the RX FIFO is empty, SHALL return 0x00 with no pop.
REQ-024 SHALL, on an IO read of 0x30004, return {6'b0, rx_nonempty, tx_full}.
REQ-025 SHALL return 0x00 for IO reads at other addresses, and SHALL ignore IO writes at other addresses.
REQ-026 SHALL drive uart_tx_valid = TX FIFO not empty and uart_tx_data = TX head; SHALL pop when valid && ready, independent of rdy.
REQ-027 SHALL push uart_rx_data when uart_rx_valid=1, independent of rdy; if the RX FIFO is full, SHALL drop the byte.
REQ-028 SHALL, on a simultaneous push and pop of the same FIFO, perform both and leave the count unchanged; when full with a pop, SHALL accept the push.
REQ-029 SHALL drive io_buffer_full registered, set when tx_count >= TX_DEPTH-2, giving a two-byte margin for in-flight initiator writes.
REQ-030 SHALL implement FIFO pointers with (log2 depth + 1) bits so that wrap-around distinguishes full from empty.

Reset
REQ-031 SHALL, while rst=0, clear ret_data, FIFO pointers, tx_overflow, sim_halt, and io_buffer_full to 0, asynchronously.
REQ-032 SHALL NOT reset RAM contents; reset deasserted mid-stream SHALL drop any FIFO contents.

Structure
REQ-033 SHALL take IO address constants (0x30000, 0x30004), ADDR_WID, and MEMORY_RW_WID from the shared const include.
REQ-034 SHALL use one sub-module, byte_fifo (parameter DEPTH), instantiated once for TX and once for RX.

Verification
REQ-035 SHALL verify: write 0xA5 to 0x00100, then read 0x00100 -> ret_data==0xA5 exactly one cycle after the read cycle.
REQ-036 SHALL verify: 6 back-to-back IO writes to 0x30000 with uart_tx_ready=0 -> io_buffer_full=1 after the 6th push, and bytes emerge in order once ready=1.
REQ-037 SHALL verify: 9 writes to a full 8-deep TX FIFO -> 9th byte dropped and tx_overflow=1.
REQ-038 SHALL verify: push RX 0x41, then read 0x30000 twice -> 0x41, then 0x00; a read of 0x30004 before the pops -> 0x02.
REQ-039 SHALL verify: rdy=0 during a write to 0x00200 -> RAM unchanged and ret_data held.
REQ-040 SHALL verify: write to 0x30004 -> sim_halt high for exactly one cycle; rst pulsed low mid-TX -> uart_tx_valid=0 immediately.

Source files
------------

// File: rtl/mem_bus_responder_pkg.sv
// Shared constants for the memory/IO bus responder:
// bus widths and the UART/halt IO register addresses.
package mem_bus_responder_pkg;

   localparam int ADDR_WID      = 32;
   localparam int MEMORY_RW_WID = 8;

   localparam logic [ADDR_WID-1:0] IO_UART_ADDR = 32'h0003_0000;
   localparam logic [ADDR_WID-1:0] IO_HALT_ADDR = 32'h0003_0004;

endpackage

// File: rtl/mem_bus_responder_byte_fifo.sv
// Byte FIFO with extra-bit pointers; a push into a full FIFO is
// still taken when a pop happens in the same cycle.
module byte_fifo
   import mem_bus_responder_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  logic [MEMORY_RW_WID-1:0]   din_i,
   input  logic                       pop_i,
   output logic [MEMORY_RW_WID-1:0]   dout_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [MEMORY_RW_WID-1:0] mem [DEPTH];
   logic [AW:0] wr_q, wr_d;
   logic [AW:0] rd_q, rd_d;
   logic        full, empty, push_ok, pop_ok;

   assign count_o = wr_q - rd_q;
   assign full    = (count_o == (AW+1)'(DEPTH));
   assign empty   = (wr_q == rd_q);
   assign pop_ok  = pop_i && !empty;
   assign push_ok = push_i && (!full || pop_ok);
   assign dout_o  = mem[rd_q[AW-1:0]];

   always_comb begin
      wr_d = wr_q + (AW+1)'(push_ok);
      rd_d = rd_q + (AW+1)'(pop_ok);
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_q[AW-1:0]] <= din_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

endmodule

// File: rtl/mem_bus_responder.sv
// Byte-wide bus responder: RAM plus UART TX/RX FIFOs and a halt
// register in the IO window (address bits [17:16] == 2'b11).
module mem_bus_responder
   import mem_bus_responder_pkg::*;
#(
   parameter int RAM_ADDR_WID = 17,
   parameter int TX_DEPTH     = 8,
   parameter int RX_DEPTH     = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rdy,
   input  logic [ADDR_WID-1:0]      call_addr,
   input  logic                     is_write,
   input  logic [MEMORY_RW_WID-1:0] write_data,
   output logic [MEMORY_RW_WID-1:0] ret_data,
   output logic                     io_buffer_full,
   output logic                     uart_tx_valid,
   output logic [MEMORY_RW_WID-1:0] uart_tx_data,
   input  logic                     uart_tx_ready,
   input  logic                     uart_rx_valid,
   input  logic [MEMORY_RW_WID-1:0] uart_rx_data,
   output logic                     sim_halt,
   output logic                     tx_overflow
);

   localparam int TXA = $clog2(TX_DEPTH);
   localparam int RXA = $clog2(RX_DEPTH);
   localparam logic [TXA:0] IO_FULL_LVL = (TXA+1)'(TX_DEPTH - 2);

   logic [MEMORY_RW_WID-1:0] ram [2**RAM_ADDR_WID];
   logic [RAM_ADDR_WID-1:0]  ram_idx;

   logic is_io, hit_uart, hit_halt, bus_rd, bus_wr;
   logic tx_push, tx_pop, tx_acc, tx_full, tx_empty;
   logic rx_pop, rx_empty;
   logic [TXA:0] tx_count, tx_cnt_nxt;
   logic [RXA:0] rx_count;
   logic [MEMORY_RW_WID-1:0] tx_head, rx_head, io_rd, rd_byte;

   logic [MEMORY_RW_WID-1:0] ret_data_q, ret_data_d;
   logic sim_halt_q, sim_halt_d;
   logic tx_ovf_q, tx_ovf_d;
   logic io_full_q, io_full_d;

   assign ram_idx  = call_addr[RAM_ADDR_WID-1:0];
   assign is_io    = (call_addr[17:16] == 2'b11);
   assign hit_uart = is_io && (call_addr == IO_UART_ADDR);
   assign hit_halt = is_io && (call_addr == IO_HALT_ADDR);
   assign bus_rd   = rdy && !is_write;
   assign bus_wr   = rdy && is_write;

   assign tx_full  = (tx_count == (TXA+1)'(TX_DEPTH));
   assign tx_empty = (tx_count == '0);
   assign rx_empty = (rx_count == '0);
   assign tx_push  = bus_wr && hit_uart;
   assign tx_pop   = !tx_empty && uart_tx_ready;
   assign tx_acc   = tx_push && (!tx_full || tx_pop);
   assign rx_pop   = bus_rd && hit_uart;

   byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk     (clk),
      .rst_n   (rst),
      .push_i  (tx_push),
      .din_i   (write_data),
      .pop_i   (tx_pop),
      .dout_o  (tx_head),
      .count_o (tx_count)
   );

   byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk     (clk),
      .rst_n   (rst),
      .push_i  (uart_rx_valid),
      .din_i   (uart_rx_data),
      .pop_i   (rx_pop),
      .dout_o  (rx_head),
      .count_o (rx_count)
   );

   always_ff @(posedge clk) begin
      if (bus_wr && !is_io) ram[ram_idx] <= write_data;
   end

   always_comb begin
      io_rd = '0;
      if (hit_uart)      io_rd = rx_empty ? '0 : rx_head;
      else if (hit_halt) io_rd = {6'b0, !rx_empty, tx_full};
      rd_byte = is_io ? io_rd : ram[ram_idx];
   end

   // io_buffer_full looks at the post-update level so it rises on
   // the same edge that takes the TX level to its threshold.
   always_comb begin
      tx_cnt_nxt = tx_count + (TXA+1)'(tx_acc) - (TXA+1)'(tx_pop);
      ret_data_d = bus_rd ? rd_byte : ret_data_q;
      sim_halt_d = bus_wr && hit_halt;
      tx_ovf_d   = tx_ovf_q | (tx_push && !tx_acc);
      io_full_d  = (tx_cnt_nxt >= IO_FULL_LVL);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ret_data_q <= '0;
         sim_halt_q <= 1'b0;
         tx_ovf_q   <= 1'b0;
         io_full_q  <= 1'b0;
      end else begin
         ret_data_q <= ret_data_d;
         sim_halt_q <= sim_halt_d;
         tx_ovf_q   <= tx_ovf_d;
         io_full_q  <= io_full_d;
      end
   end

   assign ret_data       = ret_data_q;
   assign sim_halt       = sim_halt_q;
   assign tx_overflow    = tx_ovf_q;
   assign io_buffer_full = io_full_q;
   assign uart_tx_valid  = !tx_empty;
   assign uart_tx_data   = tx_head;

endmodule
